// File: rtl/crp16_alu_pkg.sv
// Shared op encodings and control FSM states for the CRP16 multi-cycle ALU.
package crp16_alu_pkg;

   localparam logic [4:0] OP_ADD = 5'b0_0000;
   localparam logic [4:0] OP_SUB = 5'b0_0001;
   localparam logic [4:0] OP_SHL = 5'b0_1000;
   localparam logic [4:0] OP_LSR = 5'b0_1010;
   localparam logic [4:0] OP_ASR = 5'b0_1011;
   localparam logic [4:0] OP_AND = 5'b0_1100;
   localparam logic [4:0] OP_OR  = 5'b0_1101;
   localparam logic [4:0] OP_NOT = 5'b0_1110;
   localparam logic [4:0] OP_XOR = 5'b0_1111;
   localparam logic [4:0] OP_MUL = 5'b1_0000;
   localparam logic [4:0] OP_DIV = 5'b1_0001;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDiv  = 2'd2
   } state_e;

endpackage

// File: rtl/crp16_alu_mc_if.sv
// Request/result bundle between the CRP16 control path and the multi-cycle ALU.
interface crp16_alu_mc_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [4:0]       op;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic [WIDTH-1:0] result_hi;
   logic             v;
   logic             c;
   logic             n;
   logic             z;

   modport master (
      output start, op, x, y,
      input  busy, done, result, result_hi, v, c, n, z
   );

   modport slave (
      input  start, op, x, y,
      output busy, done, result, result_hi, v, c, n, z
   );
endinterface

// File: rtl/crp16_alu_muldiv.sv
// Iterative unsigned shift-add multiplier / restoring divider, one bit per clock.
// Only built when CRP16_ALU_MULDIV_EN is defined.
`ifdef CRP16_ALU_MULDIV_EN
module crp16_alu_muldiv #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             load_i,
   input  logic             is_div_i,
   input  logic             step_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             last_o,
   output logic [WIDTH-1:0] lo_o,
   output logic [WIDTH-1:0] hi_o
);
   localparam int unsigned CW = $clog2(WIDTH + 1);

   // hi: partial product / remainder; lo: multiplier / dividend shifting into quotient
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             is_div_q, is_div_d;
   logic [WIDTH:0]   sum, rem_sh, diff;

   always_comb begin
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      cnt_d    = cnt_q;
      is_div_d = is_div_q;
      sum      = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
      rem_sh   = {hi_q, lo_q[WIDTH-1]};
      diff     = rem_sh - {1'b0, opnd_q};
      if (load_i) begin
         hi_d     = '0;
         lo_d     = a_i;
         opnd_d   = b_i;
         cnt_d    = CW'(WIDTH);
         is_div_d = is_div_i;
      end else if (step_i && cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
         if (is_div_q) begin
            if (!diff[WIDTH]) begin
               hi_d = diff[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
               hi_d = rem_sh[WIDTH-1:0];
               lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
         end else begin
            {hi_d, lo_d} = {sum, lo_q[WIDTH-1:1]};
         end
      end
   end

   assign last_o = (cnt_q == CW'(1));
   assign lo_o   = lo_d;
   assign hi_o   = hi_d;

   always_ff @(posedge clock) begin
      if (!resetn) begin
         hi_q     <= '0;
         lo_q     <= '0;
         opnd_q   <= '0;
         cnt_q    <= '0;
         is_div_q <= 1'b0;
      end else begin
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opnd_q   <= opnd_d;
         cnt_q    <= cnt_d;
         is_div_q <= is_div_d;
      end
   end
endmodule
`endif

// File: rtl/crp16_alu_mc.sv
// CRP16 ALU: single-cycle add/sub/shift/logic plus iterative mul/div, registered result/flags.
// Define CRP16_ALU_MULDIV_EN to build mul/div; otherwise op[4]=1 completes at once with v=1.
module crp16_alu_mc
   import crp16_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned SHW   = $clog2(WIDTH)
) (
   input  logic          clock,
   input  logic          resetn,
   crp16_alu_mc_if.slave bus
);
   logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
   logic             v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d, done_q, done_d;
   state_e           state_q, state_d;

   logic [SHW-1:0]   sh;
   logic [WIDTH-1:0] y_eff, sc_res;
   logic [WIDTH:0]   sum;
   logic             sc_v, sc_c;

   // Single-cycle datapath; sub reuses the adder as x + ~y + 1.
   always_comb begin
      sh     = bus.y[SHW-1:0];
      y_eff  = bus.op[0] ? ~bus.y : bus.y;
      sum    = {1'b0, bus.x} + {1'b0, y_eff} + {{WIDTH{1'b0}}, bus.op[0]};
      sc_res = '0;
      sc_v   = 1'b0;
      sc_c   = 1'b0;
      if (!bus.op[3]) begin
         sc_res = sum[WIDTH-1:0];
         sc_c   = sum[WIDTH];
         sc_v   = (bus.x[WIDTH-1] == y_eff[WIDTH-1]) && (sum[WIDTH-1] != bus.x[WIDTH-1]);
      end else if (!bus.op[2]) begin
         if (bus.op == OP_ASR)      sc_res = $unsigned($signed(bus.x) >>> sh);
         else if (bus.op == OP_LSR) sc_res = bus.x >> sh;
         else                       sc_res = bus.x << sh;
      end else begin
         case (bus.op)
            OP_AND:  sc_res = bus.x & bus.y;
            OP_OR:   sc_res = bus.x | bus.y;
            OP_NOT:  sc_res = ~bus.x;
            default: sc_res = bus.x ^ bus.y;
         endcase
      end
   end

`ifdef CRP16_ALU_MULDIV_EN
   logic             md_load, md_step, md_last;
   logic [WIDTH-1:0] md_lo, md_hi;

   crp16_alu_muldiv #(
      .WIDTH (WIDTH)
   ) u_muldiv (
      .clock    (clock),
      .resetn   (resetn),
      .load_i   (md_load),
      .is_div_i (bus.op[0]),
      .step_i   (md_step),
      .a_i      (bus.x),
      .b_i      (bus.y),
      .last_o   (md_last),
      .lo_o     (md_lo),
      .hi_o     (md_hi)
   );
`endif

   always_comb begin
      result_d    = result_q;
      result_hi_d = result_hi_q;
      v_d         = v_q;
      c_d         = c_q;
      n_d         = n_q;
      z_d         = z_q;
      done_d      = 1'b0;
      state_d     = state_q;
`ifdef CRP16_ALU_MULDIV_EN
      md_load     = 1'b0;
      md_step     = 1'b0;
`endif
      unique case (state_q)
         StIdle: begin
            if (bus.start) begin
               if (!bus.op[4]) begin
                  result_d    = sc_res;
                  result_hi_d = '0;
                  v_d         = sc_v;
                  c_d         = sc_c;
                  done_d      = 1'b1;
`ifdef CRP16_ALU_MULDIV_EN
               end else if (bus.op[0] && bus.y == '0) begin
                  result_d    = '1;
                  result_hi_d = bus.x;
                  v_d         = 1'b1;
                  c_d         = 1'b0;
                  done_d      = 1'b1;
               end else begin
                  md_load = 1'b1;
                  state_d = bus.op[0] ? StDiv : StMul;
               end
`else
               end else begin
                  // Unimplemented op: v=1 lets the control FSM trap it.
                  result_d    = '0;
                  result_hi_d = '0;
                  v_d         = 1'b1;
                  c_d         = 1'b0;
                  done_d      = 1'b1;
               end
`endif
            end
         end
`ifdef CRP16_ALU_MULDIV_EN
         StMul, StDiv: begin
            md_step = 1'b1;
            if (md_last) begin
               result_d    = md_lo;
               result_hi_d = md_hi;
               v_d         = (state_q == StMul) && (md_hi != '0);
               c_d         = (state_q == StMul) && (md_hi != '0);
               done_d      = 1'b1;
               state_d     = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
      if (done_d) begin
         n_d = result_d[WIDTH-1];
         z_d = (result_d == '0);
      end
   end

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state_q     <= StIdle;
         result_q    <= '0;
         result_hi_q <= '0;
         v_q         <= 1'b0;
         c_q         <= 1'b0;
         n_q         <= 1'b0;
         z_q         <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         v_q         <= v_d;
         c_q         <= c_d;
         n_q         <= n_d;
         z_q         <= z_d;
         done_q      <= done_d;
      end
   end

   assign bus.busy      = (state_q != StIdle);
   assign bus.done      = done_q;
   assign bus.result    = result_q;
   assign bus.result_hi = result_hi_q;
   assign bus.v         = v_q;
   assign bus.c         = c_q;
   assign bus.n         = n_q;
   assign bus.z         = z_q;
endmodule

// File: tb/tb_crp16_alu_mc.sv
// Bench for crp16_alu_mc (WIDTH=16): vector table, hand sequences and a random run
// against an arithmetic reference model. Follows CRP16_ALU_MULDIV_EN like the RTL.
module tb_crp16_alu_mc;
   import crp16_alu_pkg::*;

   localparam int unsigned W = 16;

   typedef struct {
      logic [15:0] res;
      logic [15:0] hi;
      bit          v, c, n, z;
      int          lat;
   } exp_t;

   typedef struct {
      logic [4:0]  op;
      logic [15:0] x, y, res;
      bit          v, c, n, z;
   } vec_t;

   logic clock = 1'b0;
   logic resetn = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;

   crp16_alu_mc_if #(.WIDTH(W)) bus ();

   crp16_alu_mc #(
      .WIDTH (W)
   ) dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_out(input string nm, input exp_t e);
      chk({nm, ".result"}, 32'(bus.result), 32'(e.res));
      chk({nm, ".result_hi"}, 32'(bus.result_hi), 32'(e.hi));
      chk({nm, ".v"}, 32'(bus.v), 32'(e.v));
      chk({nm, ".c"}, 32'(bus.c), 32'(e.c));
      chk({nm, ".n"}, 32'(bus.n), 32'(e.n));
      chk({nm, ".z"}, 32'(bus.z), 32'(e.z));
   endtask

   // Reference model: plain integer arithmetic on the operation's meaning.
   function automatic exp_t model(input logic [4:0] op, input logic [15:0] x, input logic [15:0] y);
      exp_t   e;
      longint ux, uy, sx, sy, full, s;
      int     sh;
      ux = longint'(x);
      uy = longint'(y);
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      sh = int'(y[3:0]);
      e.lat = 1; e.hi = '0; e.v = 0; e.c = 0; e.res = '0;
      if (op[4]) begin
`ifdef CRP16_ALU_MULDIV_EN
         if (!op[0]) begin
            full = ux * uy;
            e.res = full[15:0];
            e.hi = full[31:16];
            e.c = (e.hi != 0);
            e.v = e.c;
            e.lat = W;
         end else if (uy == 0) begin
            e.res = 16'hFFFF;
            e.hi = x;
            e.v = 1;
         end else begin
            e.res = 16'(ux / uy);
            e.hi = 16'(ux % uy);
            e.lat = W;
         end
`else
         e.v = 1;
`endif
      end else if (!op[3]) begin
         if (!op[0]) begin
            full = ux + uy; s = sx + sy; e.c = (full > 65535);
         end else begin
            full = ux - uy; s = sx - sy; e.c = (ux >= uy);
         end
         e.res = full[15:0];
         e.v = (s > 32767) || (s < -32768);
      end else if (!op[2]) begin
         if (!op[1]) begin
            full = ux * (longint'(1) << sh);
            e.res = full[15:0];
         end else if (!op[0]) begin
            e.res = 16'(ux / (longint'(1) << sh));
         end else begin
            s = sx >>> sh;
            e.res = s[15:0];
         end
      end else begin
         case (op[1:0])
            2'd0: e.res = x & y;
            2'd1: e.res = x | y;
            2'd2: e.res = ~x;
            default: e.res = x ^ y;
         endcase
      end
      e.n = e.res[15];
      e.z = (e.res == 0);
      return e;
   endfunction

   // Issue one op, scramble the inputs after acceptance, then check timing and outputs.
   task automatic do_op(input string nm, input logic [4:0] op, input logic [15:0] x,
                        input logic [15:0] y, input exp_t e);
      int lat;
      @(negedge clock);
      bus.start = 1'b1; bus.op = op; bus.x = x; bus.y = y;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.x = ~x; bus.y = ~y; bus.op = ~op;
      if (e.lat == 1) begin
         chk({nm, ".done"}, 32'(bus.done), 32'd1);
         chk({nm, ".busy"}, 32'(bus.busy), 32'd0);
      end else begin
         chk({nm, ".busy0"}, 32'(bus.busy), 32'd1);
         chk({nm, ".done0"}, 32'(bus.done), 32'd0);
         lat = 0;
         for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (bus.done) begin
               lat = i;
               break;
            end
         end
         chk({nm, ".latency"}, 32'(lat), 32'(e.lat));
         chk({nm, ".busy_end"}, 32'(bus.busy), 32'd0);
      end
      chk_out(nm, e);
   endtask

   function automatic exp_t mk(input logic [15:0] res, input logic [15:0] hi, input bit v,
                               input bit c, input bit n, input bit z, input int lat);
      exp_t e;
      e.res = res; e.hi = hi; e.v = v; e.c = c; e.n = n; e.z = z; e.lat = lat;
      return e;
   endfunction

   initial begin
      vec_t vecs[$];
      exp_t e;
      logic [4:0] rop;
      logic [15:0] rx, ry;
      int ndone, first, gaps;
      logic [15:0] cap_res, cap_hi;
      bit cap_v;

      bus.start = 1'b0; bus.op = '0; bus.x = '0; bus.y = '0;
      vecs.push_back('{OP_ADD,   16'h7FFF, 16'h0001, 16'h8000, 1, 0, 1, 0});
      vecs.push_back('{OP_SUB,   16'h0005, 16'h0005, 16'h0000, 0, 1, 0, 1});
      vecs.push_back('{OP_ASR,   16'h8000, 16'h0004, 16'hF800, 0, 0, 1, 0});
      vecs.push_back('{5'b00110, 16'hFFFF, 16'h0001, 16'h0000, 0, 1, 0, 1});
      vecs.push_back('{OP_SUB,   16'h0000, 16'h0001, 16'hFFFF, 0, 0, 1, 0});
      vecs.push_back('{5'b00111, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 0});
      vecs.push_back('{5'b01001, 16'h0001, 16'h00F3, 16'h0008, 0, 0, 0, 0});
      vecs.push_back('{OP_SHL,   16'h8001, 16'h0001, 16'h0002, 0, 0, 0, 0});
      vecs.push_back('{OP_LSR,   16'h8000, 16'h000F, 16'h0001, 0, 0, 0, 0});
      vecs.push_back('{OP_ASR,   16'h7000, 16'h0014, 16'h0700, 0, 0, 0, 0});
      vecs.push_back('{OP_AND,   16'hF0F0, 16'h3C3C, 16'h3030, 0, 0, 0, 0});
      vecs.push_back('{OP_OR,    16'hF0F0, 16'h0F0F, 16'hFFFF, 0, 0, 1, 0});
      vecs.push_back('{OP_NOT,   16'h00FF, 16'h1234, 16'hFF00, 0, 0, 1, 0});
      vecs.push_back('{OP_XOR,   16'hAAAA, 16'hAAAA, 16'h0000, 0, 0, 0, 1});

      // Reset state
      repeat (3) @(posedge clock);
      #1;
      chk("reset.busy", 32'(bus.busy), 32'd0);
      chk("reset.done", 32'(bus.done), 32'd0);
      chk_out("reset", mk(16'h0, 16'h0, 0, 0, 0, 0, 1));
      @(negedge clock);
      resetn = 1'b1;

      // Back-to-back single-cycle vectors
      foreach (vecs[i]) begin
         do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].x, vecs[i].y,
               mk(vecs[i].res, 16'h0, vecs[i].v, vecs[i].c, vecs[i].n, vecs[i].z, 1));
      end
      // done is a single pulse and outputs hold while idle
      @(posedge clock); #1;
      chk("hold.done", 32'(bus.done), 32'd0);
      chk_out("hold", mk(16'h0000, 16'h0, 0, 0, 0, 1, 1));

`ifdef CRP16_ALU_MULDIV_EN
      // mul with an ignored start pulse while busy
      @(negedge clock);
      bus.start = 1'b1; bus.op = OP_MUL; bus.x = 16'h1234; bus.y = 16'h0100;
      @(posedge clock); #1;
      bus.start = 1'b0; bus.x = 16'h0001; bus.y = 16'h0001;
      chk("mulign.busy0", 32'(bus.busy), 32'd1);
      ndone = 0; first = 0; gaps = 0; cap_res = '0; cap_hi = '0; cap_v = 0;
      for (int cyc = 1; cyc <= 24; cyc++) begin
         if (cyc == 5) begin
            bus.start = 1'b1; bus.op = OP_ADD;
         end
         @(posedge clock); #1;
         bus.start = 1'b0;
         if (bus.done) begin
            ndone++;
            if (first == 0) begin
               first = cyc; cap_res = bus.result; cap_hi = bus.result_hi; cap_v = bus.v;
            end
         end
         if (cyc < 16 && !bus.busy) gaps++;
      end
      chk("mulign.first_done", 32'(first), 32'd16);
      chk("mulign.done_count", 32'(ndone), 32'd1);
      chk("mulign.busy_gaps", 32'(gaps), 32'd0);
      chk("mulign.result", 32'(cap_res), 32'h3400);
      chk("mulign.result_hi", 32'(cap_hi), 32'h0012);
      chk("mulign.v", 32'(cap_v), 32'd1);
      chk_out("mulign.end", mk(16'h3400, 16'h0012, 1, 1, 0, 0, 16));

      do_op("mul_plan", OP_MUL, 16'h1234, 16'h0100, mk(16'h3400, 16'h0012, 1, 1, 0, 0, 16));
      do_op("div_plan", OP_DIV, 16'd100, 16'd7, mk(16'd14, 16'd2, 0, 0, 0, 0, 16));
      do_op("div_zero", OP_DIV, 16'h1234, 16'h0000, mk(16'hFFFF, 16'h1234, 1, 0, 1, 0, 1));

      // Reset aborts an in-flight mul with no done pulse
      @(negedge clock);
      bus.start = 1'b1; bus.op = OP_MUL; bus.x = 16'hFFFF; bus.y = 16'hFFFF;
      @(posedge clock); #1;
      bus.start = 1'b0;
      repeat (4) @(posedge clock);
      @(negedge clock);
      resetn = 1'b0;
      @(posedge clock); #1;
      chk("abort.busy", 32'(bus.busy), 32'd0);
      chk("abort.done", 32'(bus.done), 32'd0);
      chk_out("abort", mk(16'h0, 16'h0, 0, 0, 0, 0, 1));
      @(negedge clock);
      resetn = 1'b1;
      ndone = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(posedge clock); #1;
         if (bus.done || bus.busy) ndone++;
      end
      chk("abort.no_done", 32'(ndone), 32'd0);
`else
      do_op("mul_unimpl", OP_MUL, 16'd3, 16'd4, mk(16'h0, 16'h0, 1, 0, 0, 1, 1));
      do_op("div_unimpl", OP_DIV, 16'h1234, 16'h0000, mk(16'h0, 16'h0, 1, 0, 0, 1, 1));
      @(negedge clock);
      resetn = 1'b0;
      @(posedge clock); #1;
      chk("rst2.busy", 32'(bus.busy), 32'd0);
      chk_out("rst2", mk(16'h0, 16'h0, 0, 0, 0, 0, 1));
      @(negedge clock);
      resetn = 1'b1;
`endif
      do_op("add_after_rst", OP_ADD, 16'd2, 16'd3, mk(16'd5, 16'h0, 0, 0, 0, 0, 1));

      // Random ops against the model
      for (int i = 0; i < 200; i++) begin
         rop = 5'($urandom_range(0, 31));
         rx = 16'($urandom);
         ry = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
         if ($urandom_range(0, 3) == 0) rx = 16'($urandom_range(0, 3));
         e = model(rop, rx, ry);
         do_op($sformatf("rnd%0d_op%0h", i, rop), rop, rx, ry, e);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
